// File: rtl/sw_input_port_if.sv
// ---------------------------------------------------------------------------
// sw_input_port_if
//   Valid/ready link that carries one captured switch byte at a time from the
//   switch input port to the processor input register (Ri).
//
//   Signals:
//     ri        data word, meaningful while ri_valid is high
//     ri_valid  source has a word available
//     ri_ready  sink takes the word on this clock edge
//
//   Modports:
//     master    the producer side (sw_input_port)
//     slave     the consumer side (processor / testbench)
// ---------------------------------------------------------------------------
interface sw_input_port_if #(
    parameter int bits = 8
) ();
    logic [bits-1:0] ri;
    logic            ri_valid;
    logic            ri_ready;

    modport master (
        output ri,
        output ri_valid,
        input  ri_ready
    );

    modport slave (
        input  ri,
        input  ri_valid,
        output ri_ready
    );
endinterface

// File: rtl/sw_input_port.sv
// ---------------------------------------------------------------------------
// sw_input_port
//   Board-side input path for the K2 processor. The 8 user switches are
//   captured whenever the centre button completes a debounced press, and each
//   captured byte is queued in a small FIFO whose head is offered to the
//   processor's Ri register over a valid/ready link.
//
//   Ports:
//     clk         system clock
//     rst         synchronous, active-high reset
//     sw          raw switch inputs (asynchronous to clk)
//     btn         raw push button (asynchronous to clk, bouncy)
//     ri_bus      master side of sw_input_port_if (ri, ri_valid, ri_ready)
//     fifo_count  current queue occupancy, 0..FIFO_DEPTH
//     overflow    sticky: a capture was dropped because the queue was full
//
//   Parameters:
//     bits             width of the captured word
//     DEBOUNCE_CYCLES  consecutive stable cycles confirming press/release (>=2)
//     FIFO_DEPTH       queue entries (power of two, >=2)
//     REPEAT_CYCLES    auto-repeat period while the button is held
//
//   Build option:
//     AUTO_REPEAT_EN   when defined, a held button re-captures the switches
//                      every REPEAT_CYCLES cycles. Undefined: one capture per
//                      press and no repeat counter is built.
// ---------------------------------------------------------------------------
module sw_input_port #(
    parameter int bits            = 8,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int FIFO_DEPTH      = 4,
    parameter int REPEAT_CYCLES   = 50_000_000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [bits-1:0]               sw,
    input  logic                          btn,
    sw_input_port_if.master               ri_bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    // -----------------------------------------------------------------------
    // Elaboration-time parameter sanity check
    // -----------------------------------------------------------------------
    if (DEBOUNCE_CYCLES < 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || REPEAT_CYCLES < 1) begin : g_param_check
        $error("sw_input_port: illegal parameter value");
    end

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PTR_W = AW + 1;
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);

    // The counter is compared against DEBOUNCE_CYCLES-2 rather than -1: the
    // cycle that moves the FSM into a WAIT state already saw one stable
    // sample, so the confirming transition lands on the DEBOUNCE_CYCLES-th
    // consecutive stable sample and cap fires one cycle later.
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 2);

    // -----------------------------------------------------------------------
    // Two-flop synchronizers
    // -----------------------------------------------------------------------
    logic [bits-1:0] sw_meta_reg;
    logic [bits-1:0] sw_s_reg;
    logic            btn_meta_reg;
    logic            btn_s_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta_reg  <= '0;
            sw_s_reg     <= '0;
            btn_meta_reg <= 1'b0;
            btn_s_reg    <= 1'b0;
        end else begin
            sw_meta_reg  <= sw;
            sw_s_reg     <= sw_meta_reg;
            btn_meta_reg <= btn;
            btn_s_reg    <= btn_meta_reg;
        end
    end

    // -----------------------------------------------------------------------
    // Debounce FSM with registered one-cycle capture pulse
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE,
        WAIT_PRESS,
        PRESSED,
        WAIT_RELEASE
    } state_t;

    state_t          state_reg;
    logic [DB_W-1:0] db_cnt_reg;
    logic            cap_reg;

`ifdef AUTO_REPEAT_EN
    localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    logic [REP_W-1:0] rep_cnt_reg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            db_cnt_reg  <= '0;
            cap_reg     <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rep_cnt_reg <= '0;
`endif
        end else begin
            cap_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (btn_s_reg) begin
                        state_reg  <= WAIT_PRESS;
                        db_cnt_reg <= '0;
                    end
                end

                WAIT_PRESS: begin
                    if (!btn_s_reg) begin
                        state_reg <= IDLE;
                    end else if (db_cnt_reg == DB_LAST) begin
                        state_reg   <= PRESSED;
                        db_cnt_reg  <= '0;
                        cap_reg     <= 1'b1;
`ifdef AUTO_REPEAT_EN
                        rep_cnt_reg <= '0;
`endif
                    end else begin
                        db_cnt_reg <= db_cnt_reg + DB_W'(1);
                    end
                end

                PRESSED: begin
                    if (!btn_s_reg) begin
                        state_reg   <= WAIT_RELEASE;
                        db_cnt_reg  <= '0;
`ifdef AUTO_REPEAT_EN
                        rep_cnt_reg <= '0;
`endif
                    end
`ifdef AUTO_REPEAT_EN
                    else if (rep_cnt_reg == REP_LAST) begin
                        // Held long enough: take another sample of the switches.
                        cap_reg     <= 1'b1;
                        rep_cnt_reg <= '0;
                    end else begin
                        rep_cnt_reg <= rep_cnt_reg + REP_W'(1);
                    end
`endif
                end

                WAIT_RELEASE: begin
                    if (btn_s_reg) begin
                        // Release bounce: still pressed, no new capture.
                        state_reg   <= PRESSED;
`ifdef AUTO_REPEAT_EN
                        rep_cnt_reg <= '0;
`endif
                    end else if (db_cnt_reg == DB_LAST) begin
                        state_reg  <= IDLE;
                        db_cnt_reg <= '0;
                    end else begin
                        db_cnt_reg <= db_cnt_reg + DB_W'(1);
                    end
                end

                default: begin
                    state_reg  <= IDLE;
                    db_cnt_reg <= '0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Capture FIFO
    //   Pointers carry one extra wrap bit so that full (difference ==
    //   FIFO_DEPTH) and empty (difference == 0) are distinct.
    // -----------------------------------------------------------------------
    logic [bits-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic             overflow_reg;

    logic [PTR_W-1:0] count;
    logic             empty;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    assign count = wr_ptr_reg - rd_ptr_reg;
    assign empty = (count == '0);
    assign full  = (count == PTR_W'(FIFO_DEPTH));
    assign pop   = !empty && ri_bus.ri_ready;
    // A full queue still accepts the capture when the head leaves this cycle.
    assign push  = cap_reg && (!full || pop);
    assign drop  = cap_reg && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= sw_s_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Head is read combinationally so data and valid appear together; an
    // empty queue presents zero instead of a stale or uninitialised entry.
    assign ri_bus.ri       = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];
    assign ri_bus.ri_valid = !empty;
    assign fifo_count      = count;
    assign overflow        = overflow_reg;

endmodule

// File: tb/tb_sw_input_port.sv
module tb_sw_input_port;

    localparam int BITS  = 8;
    localparam int DEB   = 4;
    localparam int DEPTH = 4;
    localparam int REP   = 10;

`ifdef AUTO_REPEAT_EN
    localparam int EXP_LONG_PRESS = 2;   // 20-cycle hold: initial cap + one repeat
    localparam int EXP_HOLD35     = 4;   // caps at t, t+10, t+20, t+30
`else
    localparam int EXP_LONG_PRESS = 1;
    localparam int EXP_HOLD35     = 1;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [BITS-1:0] sw;
    logic            btn;
    logic [2:0]      fifo_count;
    logic            overflow;

    sw_input_port_if #(.bits(BITS)) bus ();

    sw_input_port #(
        .bits            (BITS),
        .DEBOUNCE_CYCLES (DEB),
        .FIFO_DEPTH      (DEPTH),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw         (sw),
        .btn        (btn),
        .ri_bus     (bus),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst          = 1'b1;
        btn          = 1'b0;
        bus.ri_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();
    endtask

    // One clean press: hold for 'hold' cycles, then a full release.
    task automatic do_press(input logic [7:0] v, input int hold);
        sw  = v;
        btn = 1'b1;
        repeat (hold) tick();
        btn = 1'b0;
        repeat (10) tick();
        $display("press sw=%02h count=%0d overflow=%0d", v, fifo_count, overflow);
    endtask

    task automatic do_pop();
        $display("pop ri=%02h count=%0d", bus.ri, fifo_count);
        bus.ri_ready = 1'b1;
        tick();
        bus.ri_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.ri_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sw  = 8'($urandom);
            btn = 1'($urandom);
            tick();
        end
        checks++; if (bus.ri !== 8'h00) begin failures++; $display("FAIL reset_ri got=%02h exp=00", bus.ri); end
        checks++; if (bus.ri_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.ri_valid); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        $display("reset done");
        btn = 1'b0;
        rst = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_clean_press();
        int lat;
        lat = -1;
        sw  = 8'hA5;
        btn = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (lat < 0 && bus.ri_valid === 1'b1) lat = k;
        end
        $display("press sw=a5 valid_after=%0d", lat);
        checks++; if (lat != 7) begin failures++; $display("FAIL press_latency got=%0d exp=7", lat); end
        checks++; if (bus.ri !== 8'hA5) begin failures++; $display("FAIL press_data got=%02h exp=a5", bus.ri); end
        checks++; if (fifo_count !== 3'(EXP_LONG_PRESS)) begin failures++; $display("FAIL press_count got=%0d exp=%0d", fifo_count, EXP_LONG_PRESS); end
        // Switches move after the capture; queued entry must not follow them.
        sw  = 8'hFF;
        btn = 1'b0;
        repeat (10) tick();
        checks++; if (bus.ri !== 8'hA5) begin failures++; $display("FAIL press_hold_data got=%02h exp=a5", bus.ri); end
        do_pop();
        checks++; if (fifo_count !== 3'(EXP_LONG_PRESS - 1)) begin failures++; $display("FAIL pop_count got=%0d exp=%0d", fifo_count, EXP_LONG_PRESS - 1); end
        checks++; if (bus.ri_valid !== (EXP_LONG_PRESS > 1)) begin failures++; $display("FAIL pop_valid got=%b exp=%b", bus.ri_valid, EXP_LONG_PRESS > 1); end
    endtask

    task automatic test_bounce();
        logic [7:0] pattern;
        apply_reset();
        sw      = 8'h77;
        pattern = 8'b1100_1100;
        for (int i = 7; i >= 0; i--) begin
            btn = pattern[i];
            tick();
        end
        btn = 1'b0;
        repeat (12) tick();
        $display("bounce count=%0d", fifo_count);
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL bounce_count got=%0d exp=0", fifo_count); end
        checks++; if (bus.ri_valid !== 1'b0) begin failures++; $display("FAIL bounce_valid got=%b exp=0", bus.ri_valid); end
    endtask

    task automatic test_overflow_order();
        apply_reset();
        for (int i = 1; i <= 4; i++) do_press(8'(i), 8);
        checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", fifo_count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fill_overflow got=%b exp=0", overflow); end
        do_press(8'd5, 8);
        checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", fifo_count); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        for (int i = 1; i <= 4; i++) begin
            checks++; if (bus.ri !== 8'(i)) begin failures++; $display("FAIL drain_order got=%02h exp=%02h", bus.ri, 8'(i)); end
            do_pop();
        end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL drain_count got=%0d exp=0", fifo_count); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        // Empty with ready held: nothing may move.
        bus.ri_ready = 1'b1;
        repeat (3) tick();
        bus.ri_ready = 1'b0;
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL empty_pop_count got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_reset_midway();
        do_press(8'h11, 8);
        do_press(8'h22, 8);
        sw  = 8'h33;
        btn = 1'b1;
        repeat (4) tick();           // FSM now counting in WAIT_PRESS
        rst = 1'b1;
        btn = 1'b0;
        tick();
        $display("mid reset count=%0d overflow=%0d", fifo_count, overflow);
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL midrst_count got=%0d exp=0", fifo_count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL midrst_overflow got=%b exp=0", overflow); end
        checks++; if (bus.ri_valid !== 1'b0 || bus.ri !== 8'h00) begin failures++; $display("FAIL midrst_head got=%b/%02h exp=0/00", bus.ri_valid, bus.ri); end
        rst = 1'b0;
        repeat (12) tick();
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL midrst_after_count got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_seq [4];
        exp_seq[0] = 8'd2; exp_seq[1] = 8'd3; exp_seq[2] = 8'd4; exp_seq[3] = 8'd9;
        apply_reset();
        for (int i = 1; i <= 4; i++) do_press(8'(i), 8);
        checks++; if (bus.ri !== 8'd1) begin failures++; $display("FAIL full_head got=%02h exp=01", bus.ri); end
        sw  = 8'd9;
        btn = 1'b1;
        repeat (6) tick();           // cap is high in the next cycle
        bus.ri_ready = 1'b1;
        tick();
        bus.ri_ready = 1'b0;
        $display("push+pop sw=09 ri=%02h count=%0d overflow=%0d", bus.ri, fifo_count, overflow);
        checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL pp_count got=%0d exp=4", fifo_count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL pp_overflow got=%b exp=0", overflow); end
        repeat (2) tick();
        btn = 1'b0;
        repeat (10) tick();
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.ri !== exp_seq[i]) begin failures++; $display("FAIL pp_order got=%02h exp=%02h", bus.ri, exp_seq[i]); end
            do_pop();
        end
        checks++; if (bus.ri_valid !== 1'b0) begin failures++; $display("FAIL pp_empty got=%b exp=0", bus.ri_valid); end
    endtask

    task automatic test_repeat();
        apply_reset();
        sw  = 8'h3C;
        btn = 1'b1;
        repeat (6 + 35) tick();
        btn = 1'b0;
        repeat (12) tick();
        $display("hold sw=3c count=%0d overflow=%0d", fifo_count, overflow);
        checks++; if (fifo_count !== 3'(EXP_HOLD35)) begin failures++; $display("FAIL repeat_count got=%0d exp=%0d", fifo_count, EXP_HOLD35); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL repeat_overflow got=%b exp=0", overflow); end
        for (int i = 0; i < EXP_HOLD35; i++) begin
            checks++; if (bus.ri !== 8'h3C) begin failures++; $display("FAIL repeat_data got=%02h exp=3c", bus.ri); end
            do_pop();
        end
        checks++; if (bus.ri_valid !== 1'b0) begin failures++; $display("FAIL repeat_empty got=%b exp=0", bus.ri_valid); end
    endtask

    initial begin
        rst          = 1'b1;
        sw           = '0;
        btn          = 1'b0;
        bus.ri_ready = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_overflow_order();
        test_reset_midway();
        test_full_push_pop();
        test_repeat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sw_input_port.md
Name: sw_input_port

Overview:
- Input-side counterpart to the Ro display path on the FPGA board.
- Captures the 8 user switches when the centre button gets a debounced press, and queues each captured byte in a small FIFO.
- Presents the queue head to the K2 processor input register (Ri) through a valid/ready handshake.
- Sits between the board pins (SW, BTNC) and the processor's Ri input in the FPGA top level.

Parameters:
- bits, 8: width of the captured switch word and of Ri.
- DEBOUNCE_CYCLES, 1_000_000: number of consecutive stable clk cycles that confirm a press or a release; minimum 2.
- FIFO_DEPTH, 4: number of queue entries; must be a power of 2, minimum 2.
- REPEAT_CYCLES, 50_000_000: auto-repeat period. Used only when AUTO_REPEAT_EN is defined.

Ports:
- clk, input, 1: system clock (100 MHz on board).
- rst, input, 1: synchronous, active-high reset.
- sw, input, bits: raw switch inputs, asynchronous to clk.
- btn, input, 1: raw push-button input, asynchronous to clk, bouncy.
- ri, output, bits: FIFO head data sent to the processor.
- ri_valid, output, 1: FIFO not empty.
- ri_ready, input, 1: processor accepts ri this cycle.
- fifo_count, output, $clog2(FIFO_DEPTH)+1: current occupancy.
- overflow, output, 1: sticky flag, set when a capture is dropped.

Behaviour:
- Reset: all of the following are synchronous on rst.
  - Outputs: ri=0, ri_valid=0, fifo_count=0, overflow=0.
  - Internal: FSM=IDLE, debounce counter=0, synchronizers=0, FIFO pointers=0.
- Synchronization: sw and btn each pass through a 2-flop synchronizer (sw_s, btn_s). Logic past that point uses only the synchronized values.
- Debounce FSM states:
  - IDLE: if btn_s=1, go to WAIT_PRESS with counter=0.
  - WAIT_PRESS: counter increments while btn_s=1. If btn_s=0, return to IDLE. When counter reaches DEBOUNCE_CYCLES-1, go to PRESSED and assert the one-cycle pulse cap.
  - PRESSED: if btn_s=0, go to WAIT_RELEASE with counter=0.
  - WAIT_RELEASE: counter increments while btn_s=0. If btn_s=1, return to PRESSED. When counter reaches DEBOUNCE_CYCLES-1, go to IDLE.
- Capture: on cap, push sw_s (the value sampled that same cycle) into the FIFO.
- Exactly one push per debounced press. Bounces shorter than DEBOUNCE_CYCLES produce no push.
- Latency: from a btn rise that stays stable to ri_valid=1 on an empty FIFO is 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
- FIFO:
  - Circular buffer with read and write pointers one bit wider than the address, so full and empty are distinguishable.
  - ri is driven combinationally from mem[rd_ptr], so data is valid in the same cycle as ri_valid.
  - Pop when ri_valid && ri_ready.
  - ri and ri_valid stay stable until popped.
- Boundary conditions:
  - Empty with ri_ready=1: no pop; pointers unchanged.
  - Full with push and pop in the same cycle: both occur; count stays at FIFO_DEPTH.
  - Full with push and no pop: the data is dropped and overflow is set to 1. overflow stays set until rst.
  - Push and pop in the same cycle with 0 < count < FIFO_DEPTH: count unchanged.
  - Pointer wrap-around is modulo 2·FIFO_DEPTH and needs no special case.
  - Changes to sw after cap do not alter already-queued entries.
  - rst during WAIT_PRESS or while the FIFO is partially filled: everything returns to reset state on the next edge, and queued data is discarded.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined:
  - While the FSM is in PRESSED, a repeat counter runs.
  - Every REPEAT_CYCLES cycles it asserts cap again, which pushes the current sw_s.
  - The counter is cleared on entry to PRESSED and on leaving it.
  - The first repeat occurs REPEAT_CYCLES cycles after the initial cap.
- Not defined: no repeat counter exists, and PRESSED produces no further pushes.

Test Plan (bench uses DEBOUNCE_CYCLES=4, FIFO_DEPTH=4, REPEAT_CYCLES=10):
1. Reset: hold rst=1 for 3 cycles with random sw/btn → ri=0, ri_valid=0, fifo_count=0, overflow=0.
2. Clean press: sw=8'hA5, btn=1 for 20 cycles with ri_ready=0 → ri_valid rises exactly 7 cycles after the btn rise, ri=8'hA5, fifo_count=1. Then ri_ready=1 for 1 cycle → ri_valid=0, fifo_count=0.
3. Bounce rejection: btn toggles 1,0,1,0 every 2 cycles, then settles to 0 → no push; fifo_count stays 0.
4. Ordering and overflow: 5 clean presses with sw=1,2,3,4,5 and ri_ready=0 → fifo_count=4, overflow=1. Draining gives ri sequence 1,2,3,4.
5. Full with simultaneous push/pop: FIFO holds 1,2,3,4; a 5th press with sw=9 is confirmed while ri_ready=1 in the cap cycle → 1 is popped, 9 is queued, overflow stays 0, fifo_count=4.
6. AUTO_REPEAT_EN: hold btn=1 with sw=8'h3C for 35 cycles past cap → 4 pushes total (cap at t, t+10, t+20, t+30). Without the macro → 1 push.
